// File: rtl/cpu_pkg.sv
// Shared pipeline types: skid slot states and packed stage payload widths.
// Imported by the elastic register chain and its handshake interface.
package cpu_pkg;

   localparam int SLOT_W = 2;

   typedef enum logic [SLOT_W-1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_BUSY  = 2'd1,
      SLOT_FULL  = 2'd2
   } slot_state_e;

   // pc | instr
   localparam int IF_ID_W  = 64;
   // pc | rs1 | rs2 | imm | rd | ctrl
   localparam int ID_EX_W  = 139;
   // alu | store | rd | ctrl
   localparam int EX_MEM_W = 73;
   // rd_we | rd_addr | rd_data
   localparam int MEM_WB_W = 38;

   // Occupancy counter width for a chain holding up to 2*n beats.
   function automatic int occ_w(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/pipe_skid_chain_if.sv
// Valid/ready bundle of the elastic chain: upstream side, downstream side,
// flush and occupancy, with producer/consumer modports.
interface pipe_skid_chain_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_STAGES = 1
);
   import cpu_pkg::*;

   localparam int CNT_W = occ_w(NUM_STAGES);

   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [CNT_W-1:0]  occupancy;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );

endinterface

// File: rtl/pipe_skid_slot.sv
// One elastic slot: main register plus skid register, with ready/valid
// flopped from the slot state so no combinational path crosses the slot.
module pipe_skid_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   input  logic              dn_ready
);
   import cpu_pkg::*;

   slot_state_e       state;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              accept;
   logic              drain;

   assign accept  = up_valid & up_ready;
   assign drain   = dn_valid & dn_ready;
   assign dn_data = main_q;

   // Slot FSM; main always holds the oldest beat, skid the younger one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SLOT_EMPTY;
         up_ready <= 1'b1;
         dn_valid <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         state    <= SLOT_EMPTY;
         up_ready <= 1'b1;
         dn_valid <= 1'b0;
      end else begin
         unique case (state)
            SLOT_EMPTY: begin
               if (accept) begin
                  main_q   <= up_data;
                  state    <= SLOT_BUSY;
                  up_ready <= 1'b1;
                  dn_valid <= 1'b1;
               end
            end
            SLOT_BUSY: begin
               if (accept && drain) begin
                  main_q <= up_data;
               end else if (accept) begin
                  skid_q   <= up_data;
                  state    <= SLOT_FULL;
                  up_ready <= 1'b0;
               end else if (drain) begin
                  state    <= SLOT_EMPTY;
                  dn_valid <= 1'b0;
               end
            end
            SLOT_FULL: begin
               if (drain) begin
                  main_q   <= skid_q;
                  state    <= SLOT_BUSY;
                  up_ready <= 1'b1;
               end
            end
            default: begin
               state    <= SLOT_EMPTY;
               up_ready <= 1'b1;
               dn_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_skid_chain.sv
// Elastic pipeline register chain of NUM_STAGES skid slots with
// backpressure, synchronous flush and occupancy reporting.
module pipe_skid_chain #(
   parameter int DATA_W     = 32,
   parameter int NUM_STAGES = 1
) (
   input  logic           clk,
   input  logic           rst,
   pipe_skid_chain_if.slave bus
);
   import cpu_pkg::*;

   localparam int CNT_W = occ_w(NUM_STAGES);

   logic [NUM_STAGES:0] vld;
   logic [NUM_STAGES:0] rdy;
   logic [DATA_W-1:0]   dat [NUM_STAGES+1];
   logic [CNT_W-1:0]    occ_q;
   logic                in_xfer;
   logic                out_xfer;

   assign vld[0]          = bus.in_valid;
   assign dat[0]          = bus.in_data;
   assign rdy[NUM_STAGES] = bus.out_ready;

   genvar k;
   generate
      for (k = 0; k < NUM_STAGES; k++) begin : g_slot
         pipe_skid_slot #(
            .DATA_W (DATA_W)
         ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.flush),
            .up_valid (vld[k]),
            .up_data  (dat[k]),
            .up_ready (rdy[k]),
            .dn_valid (vld[k+1]),
            .dn_data  (dat[k+1]),
            .dn_ready (rdy[k+1])
         );
      end
   endgenerate

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vld[NUM_STAGES];
   assign bus.out_data  = dat[NUM_STAGES];
   assign bus.occupancy = occ_q;

   assign in_xfer  = bus.in_valid & rdy[0];
   assign out_xfer = vld[NUM_STAGES] & bus.out_ready;

   // Beat count: +1 per input transfer, -1 per output transfer, flush clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q <= '0;
      end else if (bus.flush) begin
         occ_q <= '0;
      end else if (in_xfer && !out_xfer) begin
         occ_q <= occ_q + CNT_W'(1);
      end else if (out_xfer && !in_xfer) begin
         occ_q <= occ_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Directed and scoreboard bench for the elastic skid chain at
// depths 3, 2 and 1.
module tb_pipe_skid_chain;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   int nxt, expd, nout, stalls, m, seed;
   bit acc, in_x, out_x, pend, stall_prev, got;
   logic [31:0] prev_d;
   logic [31:0] q [$];

   pipe_skid_chain_if #(.DATA_W(32), .NUM_STAGES(3)) b3 ();
   pipe_skid_chain_if #(.DATA_W(32), .NUM_STAGES(2)) b2 ();
   pipe_skid_chain_if #(.DATA_W(MEM_WB_W), .NUM_STAGES(1)) b1 ();

   pipe_skid_chain #(.DATA_W(32), .NUM_STAGES(3)) u3 (
      .clk (clk), .rst (rst), .bus (b3.slave)
   );
   pipe_skid_chain #(.DATA_W(32), .NUM_STAGES(2)) u2 (
      .clk (clk), .rst (rst), .bus (b2.slave)
   );
   pipe_skid_chain #(.DATA_W(MEM_WB_W), .NUM_STAGES(1)) u1 (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );

   task automatic chk(input string tag,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      seed = $urandom(32'd2024);
      rst = 1'b0;
      b3.flush = 0; b3.in_valid = 0; b3.in_data = '0; b3.out_ready = 0;
      b2.flush = 0; b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 0;
      b1.flush = 0; b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_vld", b3.out_valid, 0);
      chk("rst_rdy", b3.in_ready, 1);
      chk("rst_occ", b3.occupancy, 0);
      chk("rst_dat", b3.out_data, 0);
      rst = 1'b1;

      // reset mid-stream with 3 beats held
      b3.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         b3.in_valid = 1;
         b3.in_data  = 32'(32'hA0 + i);
         @(negedge clk);
      end
      b3.in_valid = 0;
      chk("t1_occ", b3.occupancy, 3);
      chk("t1_vld", b3.out_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("t1_rst_vld", b3.out_valid, 0);
      chk("t1_rst_rdy", b3.in_ready, 1);
      chk("t1_rst_occ", b3.occupancy, 0);
      chk("t1_rst_dat", b3.out_data, 0);
      @(negedge clk);
      rst = 1'b1;

      // streaming 0x10..0x1F at depth 3
      b3.out_ready = 1;
      for (int c = 0; c < 21; c++) begin
         acc = (c >= 3 && c <= 18);
         chk("t2_vld", b3.out_valid, acc);
         if (acc) chk("t2_dat", b3.out_data, 64'(16 + c - 3));
         m = ((c < 16) ? c : 16) - ((c < 3) ? 0 : ((c - 3 < 16) ? c - 3 : 16));
         chk("t2_occ", b3.occupancy, m);
         chk("t2_rdy", b3.in_ready, 1);
         b3.in_valid = (c < 16);
         b3.in_data  = 32'(16 + c);
         @(negedge clk);
      end
      b3.in_valid = 0;

      // fill depth 3 completely, then flush with an input beat present
      b3.out_ready = 0;
      nxt = 32'hB0;
      for (int c = 0; c < 10; c++) begin
         b3.in_valid = 1;
         b3.in_data  = 32'(nxt);
         acc = b3.in_ready;
         @(negedge clk);
         if (acc) nxt++;
      end
      chk("t4_acc", nxt, 32'hB6);
      chk("t4_full_occ", b3.occupancy, 6);
      chk("t4_full_rdy", b3.in_ready, 0);
      b3.flush    = 1;
      b3.in_valid = 1;
      b3.in_data  = 32'hDEAD;
      @(negedge clk);
      b3.flush    = 0;
      b3.in_valid = 0;
      chk("t4_occ", b3.occupancy, 0);
      chk("t4_vld", b3.out_valid, 0);
      chk("t4_rdy", b3.in_ready, 1);
      chk("t4_hold", b3.out_data, 32'hB0);
      b3.in_valid  = 1;
      b3.in_data   = 32'h77;
      b3.out_ready = 1;
      @(negedge clk);
      b3.in_valid = 0;
      got = 0;
      for (int k = 0; k < 8; k++) begin
         if (!got && b3.out_valid) begin
            chk("t4_first", b3.out_data, 32'h77);
            got = 1;
         end
         @(negedge clk);
      end
      chk("t4_seen", got, 1);
      chk("t4_end_occ", b3.occupancy, 0);

      // backpressure at depth 2
      b2.out_ready = 0;
      nxt = 32'h21;
      for (int c = 0; c < 8; c++) begin
         b2.in_valid = (nxt <= 32'h26);
         b2.in_data  = 32'(nxt);
         acc = b2.in_valid && b2.in_ready;
         @(negedge clk);
         if (acc) nxt++;
      end
      chk("t3_acc", nxt, 32'h25);
      chk("t3_rdy", b2.in_ready, 0);
      chk("t3_occ", b2.occupancy, 4);
      b2.out_ready = 1;
      expd = 32'h21;
      for (int c = 0; c < 20; c++) begin
         if (b2.out_valid) begin
            chk("t3_dat", b2.out_data, 32'(expd));
            expd++;
         end
         b2.in_valid = (nxt <= 32'h26);
         b2.in_data  = 32'(nxt);
         acc = b2.in_valid && b2.in_ready;
         @(negedge clk);
         if (acc) nxt++;
      end
      b2.in_valid = 0;
      chk("t3_nout", expd, 32'h27);
      chk("t3_nin", nxt, 32'h27);
      chk("t3_end_occ", b2.occupancy, 0);

      // random valid/ready against a FIFO scoreboard at depth 3
      pend = 0;
      stall_prev = 0;
      prev_d = '0;
      for (int c = 0; c < 4000; c++) begin
         chk("t5_occ", b3.occupancy, q.size());
         if (q.size() == 0) chk("t5_empty_vld", b3.out_valid, 0);
         else if (b3.out_valid) chk("t5_dat", b3.out_data, q[0]);
         if (stall_prev) begin
            chk("t5_hold_vld", b3.out_valid, 1);
            chk("t5_hold_dat", b3.out_data, prev_d);
         end
         if (!pend) begin
            b3.in_valid = ($urandom_range(0, 99) < 60);
            b3.in_data  = $urandom;
         end
         b3.out_ready = ($urandom_range(0, 99) < 55);
         in_x  = b3.in_valid && b3.in_ready;
         out_x = b3.out_valid && b3.out_ready;
         if (out_x && q.size() > 0) void'(q.pop_front());
         if (in_x) q.push_back(b3.in_data);
         pend       = b3.in_valid && !in_x;
         stall_prev = b3.out_valid && !b3.out_ready;
         prev_d     = b3.out_data;
         @(negedge clk);
      end
      b3.in_valid  = 0;
      b3.out_ready = 1;
      repeat (10) @(negedge clk);
      chk("t5_drain_occ", b3.occupancy, 0);

      // depth 1, 38-bit payload, out_ready toggling every cycle
      nxt = 1; expd = 1; nout = 0; stalls = 0; m = 0;
      for (int c = 0; c < 40; c++) begin
         chk("t6_occ", b1.occupancy, m);
         chk("t6_rdy", b1.in_ready, m != 2);
         b1.out_ready = (c % 2 == 0);
         b1.in_valid  = 1;
         b1.in_data   = 38'(nxt);
         if (b1.out_valid && b1.out_ready) begin
            chk("t6_dat", b1.out_data, 64'(expd));
            expd++;
            nout++;
            m--;
         end
         if (b1.in_ready) begin
            nxt++;
            m++;
         end
         else stalls++;
         @(negedge clk);
      end
      b1.in_valid = 0;
      chk("t6_nout", nout, 19);
      chk("t6_stall", stalls > 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
